uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
// - Byte buffer directly downstream of the UART receiver; consumes its data_out/data_ready pair.
// - Captures each received byte into a circular FIFO and lets the CPU-side logic drain it at its own pace.
// - Reports the occupancy level, full/empty status and sticky overflow so that bytes lost at 9600 baud are visible.
// PARAMETERS
// - DATA_WIDTH  8   width of one stored character
// - DEPTH       16  number of FIFO entries; must be a power of 2, minimum 2
// - ADDR_W      $clog2(DEPTH)  pointer width; derived, never overridden
// PORTS
// - clk           in   1             system clock
// - nRst          in   1             reset; synchronous, active-high (name kept per codebase)
// - enable        in   1             1 = accept incoming bytes; 0 = ignore rx_valid
// - rx_data       in   DATA_WIDTH    byte from the receiver (data_out)
// - rx_valid      in   1             receiver data_ready; may be held high for more than one cycle
// - rd_en         in   1             pop request from the consumer
// - rd_data       out  DATA_WIDTH    popped byte, registered
// - rd_valid      out  1             1-cycle pulse; rd_data is valid in that cycle
// - count         out  ADDR_W+1      entries held, 0..DEPTH
// - empty         out  1             count == 0
// - full          out  1             count == DEPTH
// - overflow      out  1             sticky; set when a byte is dropped
// - clr_overflow  in   1             synchronous clear of overflow
// BEHAVIOUR
// - Reset (nRst=1 at posedge) values:
//   - rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0.
//   - Write and read pointers = 0; rx_valid_d = 0.
//   - Reset mid-transfer discards all contents; the array itself is not cleared.
// - Write strobe: wr = enable & rx_valid & ~rx_valid_d (rising-edge detect).
//   - rx_valid_d <= rx_valid every cycle, regardless of enable.
//   - A level held for N cycles yields exactly one write.
// - Accepted write: mem[wptr] <= rx_data; wptr increments mod DEPTH, wrapping from DEPTH-1 to 0.
// - Read: rd = rd_en & ~empty.
//   - rd_data <= mem[rptr]; rptr increments mod DEPTH; rd_valid=1 the next cycle (latency 1).
//   - rd_en while empty is ignored: rd_valid=0, rd_data holds its value, no error flag.
// - Simultaneous wr and rd:
//   - Not full: both happen; count is unchanged.
//   - Full: the read frees a slot, so the write is accepted and count stays DEPTH; no overflow.
//   - Empty: the read is ignored (no bypass); the write is stored and count becomes 1.
// - Write while full without a read: byte dropped, pointers unchanged, overflow <= 1.
// - Overflow clear:
//   - clr_overflow=1 clears overflow next cycle.
//   - Drop and clr_overflow in the same cycle: overflow ends at 1 (set wins).
// - count, empty and full are registered and consistent with the pointers in the same cycle.
// - Output timing: rd_data, rd_valid and count change one clk after the causing edge.
// - No combinational path from rd_en to any output.
// CONFIGURATION
// - Macro UART_RX_FIFO_DROP_CNT_EN.
// - Defined:
//   - Adds output drop_count [7:0], reset 0.
//   - drop_count increments on every dropped byte and saturates at 255.
//   - clr_overflow also clears drop_count to 0; a drop in the same cycle leaves drop_count = 1.
// - Undefined: the port and its counter are absent; all other behaviour is identical.
// TESTING
// - Reset: pulse nRst for 2 clk -> count=0, empty=1, full=0, overflow=0, rd_valid=0.
// - Basic order:
//   - Write 0x41, 0x42, 0x43 as 1-cycle pulses, then 3 rd_en -> count=3.
//   - Reads return 0x41, 0x42, 0x43, each with rd_valid one cycle after rd_en; then empty=1.
// - Held valid: rx_valid=1 for 5 cycles with rx_data=0x55 -> count=1 and a single 0x55 is read back.
// - Overflow:
//   - Write 0x00..0x0F -> full=1, count=16.
//   - Write 0xAA -> overflow=1, count=16; draining returns 0x00..0x0F (0xAA absent).
//   - With UART_RX_FIFO_DROP_CNT_EN, drop_count=1.
// - Full simultaneous: FIFO full; write 0x99 and rd_en in the same cycle -> count stays 16, overflow=0.
//   - Draining ends with 0x99.
// - Empty read, enable=0, reset mid-op:
//   - rd_en on empty -> no rd_valid.
//   - enable=0 with a write -> count=0.
//   - 4 entries then nRst -> count=0, empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO fed by the UART receiver's data_out/data_ready.
// A rising edge of rx_valid while enabled is one write. Reads are registered with
// one cycle of latency. A sticky overflow flag records any byte dropped while full.
// Optional feature macro: UART_RX_FIFO_DROP_CNT_EN adds a saturating 8-bit drop_count output.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_W:0]       count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]     wptr_q, wptr_d;
    logic [ADDR_W-1:0]     rptr_q, rptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rx_valid_prev_q, rx_valid_prev_d;

    logic wr;
    logic rd;
    logic wr_ok;
    logic drop;

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;
`endif

    // Strobe decode, pointer/occupancy update and sticky overflow.
    always_comb begin
        wr    = enable & rx_valid & ~rx_valid_prev_q;
        rd    = rd_en & ~empty_q;
        // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
        wr_ok = wr & (~full_q | rd);
        drop  = wr & full_q & ~rd;

        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        rd_data_d       = rd_data_q;
        rd_valid_d      = rd;
        rx_valid_prev_d = rx_valid;

        if (wr_ok) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (rd) begin
            rptr_d    = rptr_q + ADDR_W'(1);
            rd_data_d = mem[rptr_q];
        end

        count_d = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd);
        empty_d = (count_d == '0);
        full_d  = (count_d == (ADDR_W+1)'(DEPTH));

        // Set has priority over clear so a drop is never lost.
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    // Saturating drop counter; clear and a same-cycle drop leave it at 1.
    always_comb begin
        drop_count_d = drop_count_q;
        if (clr_overflow) begin
            drop_count_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (nRst) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    // Storage array; deliberately not cleared on reset, pointers alone define contents.
    always_ff @(posedge clk) begin
        if (!nRst && wr_ok) begin
            mem[wptr_q] <= rx_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (nRst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
            rx_valid_prev_q <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            empty_q         <= empty_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
            rx_valid_prev_q <= rx_valid_prev_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          nRst, enable, rx_valid, rd_en, clr_overflow;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, overflow;
    logic [AW:0]   count;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0]    drop_count;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .enable       (enable),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    // Reference model state
    logic [7:0] mq[$];
    bit         m_prev, m_ovf, m_rv;
    logic [7:0] m_rd;
    int         m_drop;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock, and compare with the model.
    task automatic cyc(input bit rst, input bit en, input bit rxv, input logic [7:0] d,
                       input bit rden, input bit clr);
        bit w, r, dropped;
        nRst = rst; enable = en; rx_valid = rxv; rx_data = d; rd_en = rden; clr_overflow = clr;
        if (rst) begin
            mq.delete();
            m_prev = 0; m_ovf = 0; m_rv = 0; m_rd = 8'h00; m_drop = 0;
        end else begin
            w = en && rxv && !m_prev;
            r = rden && (mq.size() > 0);
            m_rv = r;
            if (r) m_rd = mq.pop_front();
            dropped = 0;
            if (w) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else dropped = 1;
            end
            if (dropped) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (clr) m_drop = dropped ? 1 : 0;
            else if (dropped && m_drop < 255) m_drop++;
            m_prev = rxv;
        end
        @(posedge clk);
        #1;
        chk("model count",    32'(count),    32'(mq.size()));
        chk("model empty",    32'(empty),    32'(mq.size() == 0));
        chk("model full",     32'(full),     32'(mq.size() == DEPTH));
        chk("model overflow", 32'(overflow), 32'(m_ovf));
        chk("model rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("model rd_data",  32'(rd_data),  32'(m_rd));
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("model drop_count", 32'(drop_count), 32'(m_drop));
`endif
    endtask

    typedef struct {
        bit         rst, en, rxv;
        logic [7:0] d;
        bit         rden, clr;
        int         cnt;
        bit         rv;
        logic [7:0] rdd;
        bit         ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        nRst = 1; enable = 0; rx_valid = 0; rx_data = 0; rd_en = 0; clr_overflow = 0;

        //            rst en rxv d      rden clr cnt rv rdd    ovf
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{0, 1, 1, 8'h41, 0, 0, 1, 0, 8'h00, 0};
        tbl[3]  = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0};
        tbl[4]  = '{0, 1, 1, 8'h42, 0, 0, 2, 0, 8'h00, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 0, 0, 2, 0, 8'h00, 0};
        tbl[6]  = '{0, 1, 1, 8'h43, 0, 0, 3, 0, 8'h00, 0};
        tbl[7]  = '{0, 1, 0, 8'h00, 0, 0, 3, 0, 8'h00, 0};
        tbl[8]  = '{0, 1, 0, 8'h00, 1, 0, 2, 1, 8'h41, 0};
        tbl[9]  = '{0, 1, 0, 8'h00, 1, 0, 1, 1, 8'h42, 0};
        tbl[10] = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h43, 0};
        tbl[11] = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h43, 0};
        tbl[12] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h43, 0};
        tbl[13] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h43, 0};
        tbl[14] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h43, 0};
        tbl[15] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h43, 0};
        tbl[16] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 8'h43, 0};
        tbl[17] = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h55, 0};
        tbl[18] = '{0, 0, 1, 8'h77, 0, 0, 0, 0, 8'h55, 0};
        tbl[19] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 0};

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].rxv, tbl[i].d, tbl[i].rden, tbl[i].clr);
            chk("vec count",    32'(count),    32'(tbl[i].cnt));
            chk("vec empty",    32'(empty),    32'(tbl[i].cnt == 0));
            chk("vec full",     32'(full),     32'(tbl[i].cnt == DEPTH));
            chk("vec overflow", 32'(overflow), 32'(tbl[i].ovf));
            chk("vec rd_valid", 32'(rd_valid), 32'(tbl[i].rv));
            chk("vec rd_data",  32'(rd_data),  32'(tbl[i].rdd));
        end

        // Overflow: fill, drop 0xAA, set-wins on drop+clear, drain in order.
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 8'(i), 0, 0);
            cyc(0, 1, 0, 8'h00, 0, 0);
        end
        chk("ovf full", 32'(full), 32'd1);
        chk("ovf count16", 32'(count), 32'd16);
        cyc(0, 1, 1, 8'hAA, 0, 0);
        cyc(0, 1, 0, 8'h00, 0, 0);
        chk("ovf set", 32'(overflow), 32'd1);
        chk("ovf count held", 32'(count), 32'd16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_count one", 32'(drop_count), 32'd1);
`endif
        cyc(0, 1, 1, 8'hBB, 0, 1);
        chk("ovf set wins", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_count clr+drop", 32'(drop_count), 32'd1);
`endif
        cyc(0, 1, 0, 8'h00, 0, 1);
        chk("ovf cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 8'h00, 1, 0);
            chk("drain data", 32'(rd_data), 32'(i));
        end
        chk("drain empty", 32'(empty), 32'd1);

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 8'(8'h10 + i), 0, 0);
            cyc(0, 1, 0, 8'h00, 0, 0);
        end
        cyc(0, 1, 1, 8'h99, 1, 0);
        chk("fullsim count", 32'(count), 32'd16);
        chk("fullsim ovf", 32'(overflow), 32'd0);
        chk("fullsim rd", 32'(rd_data), 32'h10);
        cyc(0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h00, 1, 0);
        chk("fullsim last", 32'(rd_data), 32'h99);
        chk("fullsim empty", 32'(empty), 32'd1);

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 8'(8'hC0 + i), 0, 0);
            cyc(0, 1, 0, 8'h00, 0, 0);
        end
        chk("midrst pre", 32'(count), 32'd4);
        cyc(1, 1, 0, 8'h00, 0, 0);
        cyc(1, 1, 0, 8'h00, 0, 0);
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst empty", 32'(empty), 32'd1);
        cyc(0, 1, 0, 8'h00, 1, 0);
        chk("midrst no rd", 32'(rd_valid), 32'd0);

        // Randomized traffic with varying read pressure.
        for (int blk = 0; blk < 8; blk++) begin
            for (int n = 0; n < 500; n++) begin
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 1) == 1,
                    8'($urandom),
                    $urandom_range(0, 3) < (blk % 4),
                    $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
